// File: rtl/nr_pkg.sv
// ---------------------------------------------------------------------------
// nr_pkg
// Shared constants and types for the Newton-Raphson divider prescale stage.
//   K0, K1       : linear reciprocal-estimate coefficients, Q2.24
//   EXP_BIAS     : IEEE-754 single exponent bias (127)
//   DEN_EXP      : biased exponent that places a mantissa in [0.5,1) (126)
//   FLAG_*       : bit positions inside the 5-bit quotient flag vector
//   state_t      : prescale FSM states
//   fp_classify  : zero / infinity / NaN decode of a single-precision value,
//                  with subnormals treated as zero
// ---------------------------------------------------------------------------
package nr_pkg;

  localparam int DM_W   = 24;   // {1, fraction} mantissa width, Q0.24
  localparam int K_W    = 26;   // coefficient width, Q2.24
  localparam int PROD_W = 50;   // Q0.24 x Q2.24 = Q2.48
  localparam int FLAG_W = 5;

  localparam logic [K_W-1:0] K0 = 26'h2D2D2D3;  // 48/17
  localparam logic [K_W-1:0] K1 = 26'h1E1E1E2;  // 32/17

  localparam logic [7:0] EXP_BIAS = 8'd127;
  localparam logic [7:0] DEN_EXP  = 8'd126;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Flag vector layout: {NaN, neg_infinite, pos_infinite, pos_zero, neg_zero}
  localparam logic [2:0] FLAG_NAN      = 3'd4;
  localparam logic [2:0] FLAG_NEG_INF  = 3'd3;
  localparam logic [2:0] FLAG_POS_INF  = 3'd2;
  localparam logic [2:0] FLAG_POS_ZERO = 3'd1;
  localparam logic [2:0] FLAG_NEG_ZERO = 3'd0;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    MULT,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  // The sign bit is not needed for classification, so only the magnitude
  // field is passed in. A zero exponent covers both true zero and the
  // subnormals that get flushed to zero.
  function automatic fp_class_t fp_classify(input logic [30:0] mag);
    fp_class_t c;
    c.is_zero = (mag[30:23] == 8'h00);
    c.is_inf  = (mag[30:23] == 8'hFF) && (mag[22:0] == 23'd0);
    c.is_nan  = (mag[30:23] == 8'hFF) && (mag[22:0] != 23'd0);
    return c;
  endfunction

endpackage

// File: rtl/nr_prescale_if.sv
// ---------------------------------------------------------------------------
// nr_prescale_if
// Operand / result handshake bundle for nr_prescale.
//   in_valid, numerator, denominator   : operand pair offered by the producer
//   in_ready                           : prescaler can accept an operand pair
//   out_valid                          : results below are valid and held
//   out_ready                          : iteration stage takes the results
//   numerator_scaled                   : N / 2^s, sign = sign(N) ^ sign(D)
//   denominator_inRange                : |D| / 2^s, inside [0.5, 1)
//   x0                                 : initial reciprocal estimate
//   flags                              : {NaN, -inf, +inf, +0, -0} of N/D
// Modports:
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the prescaler itself
// ---------------------------------------------------------------------------
interface nr_prescale_if;
  import nr_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       numerator;
  logic [31:0]       denominator;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       numerator_scaled;
  logic [31:0]       denominator_inRange;
  logic [31:0]       x0;
  logic [FLAG_W-1:0] flags;

  modport master (
    output in_valid,
    output numerator,
    output denominator,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  numerator_scaled,
    input  denominator_inRange,
    input  x0,
    input  flags
  );

  modport slave (
    input  in_valid,
    input  numerator,
    input  denominator,
    input  out_ready,
    output in_ready,
    output out_valid,
    output numerator_scaled,
    output denominator_inRange,
    output x0,
    output flags
  );

endinterface

// File: rtl/nr_seq_mult.sv
// ---------------------------------------------------------------------------
// nr_seq_mult
// Radix-2 sequential shift-add multiplier, 24-bit multiplier x 26-bit
// multiplicand -> 50-bit product. One multiplier bit is retired per cycle,
// LSB first, over exactly 24 cycles after the start edge.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : load operands and begin (one-cycle pulse)
//   multiplier    : 24-bit operand, consumed bit by bit
//   multiplicand  : 26-bit operand, added on each set multiplier bit
//   done          : high during the final step; product is complete after
//                   the edge on which done is high
//   product       : product register (valid once the run has finished)
// ---------------------------------------------------------------------------
module nr_seq_mult
  import nr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DM_W-1:0]   multiplier,
  input  logic [K_W-1:0]    multiplicand,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] prod_q;
  logic [K_W-1:0]    mcand_q;
  logic [4:0]        count_q;
  logic              busy_q;

  logic [K_W:0]      partial;
  logic [PROD_W-1:0] prod_step;

  // The upper 26 bits of the product register act as the accumulator and the
  // lower 24 bits still hold the unretired multiplier bits. Each step adds the
  // multiplicand when the current LSB is set, then shifts the whole register
  // right; the adder carry becomes the new MSB.
  always_comb begin
    partial   = {1'b0, prod_q[PROD_W-1:DM_W]};
    if (prod_q[0]) begin
      partial = partial + {1'b0, mcand_q};
    end
    prod_step = {partial, prod_q[DM_W-1:1]};
  end

  // Step counter runs 23 down to 0; the run ends on the step taken at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      prod_q  <= {{K_W{1'b0}}, multiplier};
      mcand_q <= multiplicand;
      count_q <= 5'd23;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      prod_q <= prod_step;
      if (count_q == 5'd0) begin
        busy_q <= 1'b0;
      end else begin
        count_q <= count_q - 5'd1;
      end
    end
  end

  assign done    = busy_q && (count_q == 5'd0);
  assign product = prod_q;

endmodule

// File: rtl/nr_prescale.sv
// ---------------------------------------------------------------------------
// nr_prescale
// Front end of a Newton-Raphson single-precision divider. Accepts N and D,
// shifts both by s = Ed - 126 so the divisor lands in [0.5,1), produces a
// linear reciprocal estimate x0 = K0 - K1*Dm and classifies special operand
// combinations into quotient flags.
// Ports:
//   clk    : single clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : nr_prescale_if.slave (operand and result handshakes, see the
//            interface header for the individual signals)
// Latency: out_valid rises 27 cycles after the accepting edge for normal
// operands, 2 cycles for special operands. One operation in flight at a time;
// in_ready is high only while idle.
// Build option:
//   NR_EST_ROUND_EN : when defined, the K1*Dm product and the x0 fraction use
//                     round-to-nearest-even instead of truncation. Latency is
//                     identical in both builds.
// ---------------------------------------------------------------------------
module nr_prescale
  import nr_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  nr_prescale_if.slave bus
);

  state_t state;
  state_t state_n;

  logic [31:0]       num_q;
  logic [31:0]       den_q;
  logic [31:0]       num_scaled_q;
  logic [31:0]       den_range_q;
  logic [31:0]       x0_q;
  logic [FLAG_W-1:0] flags_q;
  logic              out_valid_q;

  fp_class_t         n_cls;
  fp_class_t         d_cls;
  logic              q_sign;
  logic              q_nan;
  logic              q_inf;
  logic              q_zero;
  logic              special;
  logic [31:0]       special_val;
  logic [FLAG_W-1:0] special_flags;

  logic [9:0]        exp_raw;
  logic [31:0]       scaled_num;

  logic              mult_start;
  logic              mult_done;
  logic [PROD_W-1:0] mult_product;

  logic              prod_round_up;
  logic [K_W-1:0]    prod_q24;
  logic [K_W-1:0]    x0_fix;
  logic [31:0]       x0_norm;
  logic              frac_round_up;
  logic [31:0]       x0_val;
  logic              unused_bits;

  // -------------------------------------------------------------------------
  // Operand classification (evaluated on the registered operands in CAPTURE)
  // -------------------------------------------------------------------------
  assign n_cls  = fp_classify(num_q[30:0]);
  assign d_cls  = fp_classify(den_q[30:0]);
  assign q_sign = num_q[31] ^ den_q[31];

  // NaN takes priority; an infinite quotient is only possible once NaN is
  // ruled out, and a zero quotient only once both NaN and infinity are.
  assign q_nan  = n_cls.is_nan | d_cls.is_nan
                | (n_cls.is_zero & d_cls.is_zero)
                | (n_cls.is_inf  & d_cls.is_inf);
  assign q_inf  = !q_nan && (d_cls.is_zero || n_cls.is_inf);
  assign q_zero = !q_nan && !q_inf && (n_cls.is_zero || d_cls.is_inf);
  assign special = q_nan || q_inf || q_zero;

  always_comb begin
    special_flags = '0;
    special_val   = {q_sign, 31'd0};
    if (q_nan) begin
      special_flags[FLAG_NAN] = 1'b1;
      special_val             = QNAN;
    end else if (q_inf) begin
      special_flags[q_sign ? FLAG_NEG_INF : FLAG_POS_INF] = 1'b1;
      special_val = {q_sign, 8'hFF, 23'd0};
    end else if (q_zero) begin
      special_flags[q_sign ? FLAG_NEG_ZERO : FLAG_POS_ZERO] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Numerator scaling: En - Ed + 126 spans -127..379 for normal operands, so
  // a 10-bit two's-complement result never wraps. Bit 9 set means negative.
  // -------------------------------------------------------------------------
  assign exp_raw = {2'b00, num_q[30:23]} - {2'b00, den_q[30:23]}
                 + {2'b00, DEN_EXP};

  always_comb begin
    scaled_num = {q_sign, exp_raw[7:0], num_q[22:0]};
    if (exp_raw[9] || (exp_raw == 10'd0)) begin
      scaled_num = {q_sign, 31'd0};
    end else if (exp_raw >= 10'd255) begin
      scaled_num = {q_sign, 8'hFF, 23'd0};
    end
  end

  // -------------------------------------------------------------------------
  // Reciprocal estimate multiplier: K1 * {1, D[22:0]}
  // -------------------------------------------------------------------------
  nr_seq_mult u_mult (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mult_start),
    .multiplier   ({1'b1, den_q[22:0]}),
    .multiplicand (K1),
    .done         (mult_done),
    .product      (mult_product)
  );

  // -------------------------------------------------------------------------
  // x0 = K0 - K1*Dm, then packed as a positive single. x0 lies in
  // (16/17, 32/17], so bit 24 of the Q2.24 value selects exponent 127 vs 126
  // and bit 23 is the implied one in the 126 case.
  // -------------------------------------------------------------------------
  always_comb begin
`ifdef NR_EST_ROUND_EN
    prod_round_up = mult_product[23] &
                    ((|mult_product[22:0]) | mult_product[24]);
`else
    prod_round_up = 1'b0;
`endif
    prod_q24 = mult_product[PROD_W-1:24] + {{(K_W-1){1'b0}}, prod_round_up};
    x0_fix   = K0 - prod_q24;

    frac_round_up = 1'b0;
    if (x0_fix[24]) begin
      x0_norm = {1'b0, EXP_BIAS, x0_fix[23:1]};
`ifdef NR_EST_ROUND_EN
      // Exactly one bit is dropped, so it is either zero or an exact tie;
      // ties go to the even fraction.
      frac_round_up = x0_fix[0] & x0_fix[1];
`endif
    end else begin
      x0_norm = {1'b0, DEN_EXP, x0_fix[22:0]};
    end
    // Adding on the packed word lets a fraction carry ripple into the exponent.
    x0_val = x0_norm + {31'd0, frac_round_up};
  end

  assign unused_bits = ^{mult_product[23:0], x0_fix[25], x0_fix[0]};

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state. The multiplier is launched on the CAPTURE->MULT edge so
  // its 24 steps line up with the 24 MULT cycles.
  // -------------------------------------------------------------------------
  always_comb begin
    state_n    = state;
    mult_start = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (special) begin
          state_n = DONE;
        end else begin
          state_n    = MULT;
          mult_start = 1'b1;
        end
      end
      MULT: begin
        if (mult_done) begin
          state_n = NORM;
        end
      end
      NORM: begin
        state_n = DONE;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers. out_valid is registered off the DONE state, which
  // puts it one cycle after DONE is entered; it drops on the handshake edge
  // together with the return to IDLE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q        <= '0;
      den_q        <= '0;
      num_scaled_q <= '0;
      den_range_q  <= '0;
      x0_q         <= '0;
      flags_q      <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= (state == DONE) && !(out_valid_q && bus.out_ready);
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            num_q <= bus.numerator;
            den_q <= bus.denominator;
          end
        end
        CAPTURE: begin
          x0_q <= '0;
          if (special) begin
            num_scaled_q <= special_val;
            den_range_q  <= '0;
            flags_q      <= special_flags;
          end else begin
            num_scaled_q <= scaled_num;
            den_range_q  <= {1'b0, DEN_EXP, den_q[22:0]};
            flags_q      <= '0;
          end
        end
        NORM: begin
          x0_q <= x0_val;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready            = (state == IDLE);
  assign bus.out_valid           = out_valid_q;
  assign bus.numerator_scaled    = num_scaled_q;
  assign bus.denominator_inRange = den_range_q;
  assign bus.x0                  = x0_q;
  assign bus.flags               = flags_q;

endmodule
